// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle for the multicycle control unit.
// The controller raises ins_req / data_req and waits for the matching ack.
// Memory latency is therefore variable. An ack that arrives while its req
// is low has no effect.
interface multicycle_ctrl_fsm_if;
  logic ins_req;   // instruction fetch request
  logic ins_ack;   // instruction memory data valid
  logic data_req;  // data memory request
  logic data_ack;  // data memory transfer done

  // Controller side: issues requests, receives acknowledges
  modport master (
    output ins_req,
    output data_req,
    input  ins_ack,
    input  data_ack
  );

  // Memory side: observes requests, returns acknowledges
  modport slave (
    input  ins_req,
    input  data_req,
    output ins_ack,
    output data_ack
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for MultiCycle_CPU.
// Sequences IF/ID/EXE/EXE_B/MEM/WB for each opcode class. Instruction and
// data memory use req/ack handshakes, so their latency is variable.
// A bounded wait-state counter drives the design into a sticky ERR state.
// A retired-instruction counter counts completed instructions.
// Datapath controls are decoded combinationally from state and opcode.
// The ack and zero inputs also feed some controls directly.
module multicycle_ctrl_fsm #(
  parameter int OPW     = 6,
  parameter int ALUOPW  = 3,
  parameter int CNTW    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  multicycle_ctrl_fsm_if.master mem_if,
  input  logic [OPW-1:0]        opcode_i,
  input  logic                  zero_i,
  output logic                  PCWre_o,
  output logic                  IRWre_o,
  output logic                  RegWre_o,
  output logic                  DataMemRW_o,
  output logic                  ALUSrcB_o,
  output logic                  ALUM2Reg_o,
  output logic                  WrRegData_o,
  output logic [1:0]            ExtSel_o,
  output logic [1:0]            RegOut_o,
  output logic [1:0]            PCSrc_o,
  output logic [ALUOPW-1:0]     ALUOp_o,
  output logic [2:0]            state_o,
  output logic [CNTW-1:0]       retired_o,
  output logic                  err_o
);

  // Opcode map (instruction[31:26])
  localparam logic [OPW-1:0] OP_R    = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'h27);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'h2B);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'h03);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'h0D);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'h0C);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'h3F);

  // The wait counter must hold TIMEOUT-1. With the timeout disabled it only
  // saturates, so a single bit is enough.
  localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAITW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAITW'(TIMEOUT - 1) : '0;
  localparam logic [WAITW-1:0] WAIT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EXE   = 3'd2,
    S_EXE_B = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [WAITW-1:0]  wait_q, wait_d;
  logic [CNTW-1:0]   retired_q, retired_d;
  logic              err_q, err_d;

  logic              is_r_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s;
  logic              is_jr_s, is_zext_s, is_halt_s;
  logic              waiting_s, timeout_hit_s, retire_s;

  logic              ins_req_s, data_req_s;
  logic              pcwre_s, irwre_s, regwre_s, memrw_s;
  logic              alusrcb_s, alum2reg_s, wrregdata_s;
  logic [1:0]        extsel_s, regout_s, pcsrc_s;
  logic [ALUOPW-1:0] aluop_s;

  // Opcode class decode; opcode comes from IR and is stable from ID to WB
  always_comb begin
    is_r_s    = (opcode_i == OP_R);
    is_lw_s   = (opcode_i == OP_LW);
    is_sw_s   = (opcode_i == OP_SW);
    is_beq_s  = (opcode_i == OP_BEQ);
    is_j_s    = (opcode_i == OP_J);
    is_jal_s  = (opcode_i == OP_JAL);
    is_jr_s   = (opcode_i == OP_JR);
    is_zext_s = (opcode_i == OP_ORI) || (opcode_i == OP_ANDI);
    is_halt_s = (opcode_i == OP_HALT);
  end

  // Wait detection: a request is outstanding and its ack has not arrived
  always_comb begin
    waiting_s = ((state_q == S_IF)  && !mem_if.ins_ack) ||
                ((state_q == S_MEM) && !mem_if.data_ack);
    if (TIMEOUT != 0) begin
      timeout_hit_s = waiting_s && (wait_q == WAIT_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state and decoded datapath controls for the current state
  always_comb begin
    state_d     = state_q;
    retire_s    = 1'b0;
    ins_req_s   = 1'b0;
    data_req_s  = 1'b0;
    pcwre_s     = 1'b0;
    irwre_s     = 1'b0;
    regwre_s    = 1'b0;
    memrw_s     = 1'b0;
    alusrcb_s   = 1'b0;
    alum2reg_s  = 1'b0;
    wrregdata_s = 1'b0;
    extsel_s    = 2'b00;
    regout_s    = 2'b00;
    pcsrc_s     = 2'b00;
    aluop_s     = '0;
    case (state_q)
      S_IF: begin
        ins_req_s = 1'b1;
        if (mem_if.ins_ack) begin
          irwre_s = 1'b1;
          state_d = S_ID;
        end else if (timeout_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        if (is_j_s) begin
          pcwre_s  = 1'b1;
          pcsrc_s  = 2'b11;
          retire_s = 1'b1;
          state_d  = S_IF;
        end else if (is_jal_s) begin
          // Link: $31 <- PC+4 through the non-ALU write-data path
          pcwre_s     = 1'b1;
          pcsrc_s     = 2'b11;
          regwre_s    = 1'b1;
          regout_s    = 2'b00;
          wrregdata_s = 1'b0;
          retire_s    = 1'b1;
          state_d     = S_IF;
        end else if (is_jr_s) begin
          pcwre_s  = 1'b1;
          pcsrc_s  = 2'b10;
          retire_s = 1'b1;
          state_d  = S_IF;
        end else if (is_beq_s) begin
          state_d = S_EXE_B;
        end else if (is_halt_s) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_r_s) begin
          // Function field is decoded by the ALU control downstream
          alusrcb_s = 1'b0;
          aluop_s   = ALUOPW'(3'b111);
        end else if (is_lw_s || is_sw_s) begin
          alusrcb_s = 1'b1;
          aluop_s   = ALUOPW'(3'b000);
        end else begin
          alusrcb_s = 1'b1;
          aluop_s   = ALUOPW'(opcode_i[2:0]);
        end
        extsel_s = is_zext_s ? 2'b00 : 2'b01;
        state_d  = (is_lw_s || is_sw_s) ? S_MEM : S_WB;
      end
      S_EXE_B: begin
        alusrcb_s = 1'b0;
        aluop_s   = ALUOPW'(3'b001);
        extsel_s  = 2'b01;
        pcwre_s   = 1'b1;
        pcsrc_s   = zero_i ? 2'b01 : 2'b00;
        retire_s  = 1'b1;
        state_d   = S_IF;
      end
      S_MEM: begin
        data_req_s = 1'b1;
        memrw_s    = is_sw_s;
        if (mem_if.data_ack) begin
          if (is_sw_s) begin
            pcwre_s  = 1'b1;
            pcsrc_s  = 2'b00;
            retire_s = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        regwre_s    = 1'b1;
        pcwre_s     = 1'b1;
        pcsrc_s     = 2'b00;
        wrregdata_s = 1'b1;
        alum2reg_s  = is_lw_s;
        regout_s    = is_r_s ? 2'b10 : 2'b01;
        retire_s    = 1'b1;
        state_d     = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // Wait counter: restarts on each new request phase and saturates
  // instead of rolling over
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && ((state_d == S_IF) || (state_d == S_MEM))) begin
      wait_d = '0;
    end else if (waiting_s && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAITW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Retired counter (wraps naturally) and the sticky error flag
  always_comb begin
    retired_d = retire_s ? (retired_q + CNTW'(1)) : retired_q;
    err_d     = (state_d == S_ERR) ? 1'b1 : err_q;
  end

  // State, counters and error flag registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  // While reset is held the state already reads IF. The IF request must
  // still stay low, so every control is forced to zero until release.
  // Releasing reset mid-handshake therefore never issues a write.
  assign mem_if.ins_req  = ins_req_s   & RST_n;
  assign mem_if.data_req = data_req_s  & RST_n;
  assign PCWre_o         = pcwre_s     & RST_n;
  assign IRWre_o         = irwre_s     & RST_n;
  assign RegWre_o        = regwre_s    & RST_n;
  assign DataMemRW_o     = memrw_s     & RST_n;
  assign ALUSrcB_o       = alusrcb_s   & RST_n;
  assign ALUM2Reg_o      = alum2reg_s  & RST_n;
  assign WrRegData_o     = wrregdata_s & RST_n;
  assign ExtSel_o        = extsel_s    & {2{RST_n}};
  assign RegOut_o        = regout_s    & {2{RST_n}};
  assign PCSrc_o         = pcsrc_s     & {2{RST_n}};
  assign ALUOp_o         = aluop_s     & {ALUOPW{RST_n}};
  assign state_o         = state_q;
  assign retired_o       = retired_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm (TIMEOUT=4, CNTW=3).
// A directed vector table covers add and beq.
// Randomised instruction streams are checked against a phase-level model.
// Hand-written sequences cover timeouts, counter wrap, HALT and reset during
// a data-memory handshake.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h27;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_JR   = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_XI   = 6'h0A;

  // Flag order: ins_req data_req pcw irw regw memrw alusrcb alum2reg wrregdata
  typedef struct packed {
    logic [2:0] st;
    logic       ins_req;
    logic       data_req;
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       memrw;
    logic       alusrcb;
    logic       alum2reg;
    logic       wrregdata;
    logic [1:0] extsel;
    logic [1:0] regout;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic [2:0] ret;
    logic       err;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       ia;
    logic       da;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       pcw, irw, regw, memrw, alusrcb, alum2reg, wrregdata;
  logic [1:0] extsel, regout, pcsrc;
  logic [2:0] aluop, state, retired;
  logic       err;

  multicycle_ctrl_fsm_if mif();

  multicycle_ctrl_fsm #(.OPW(6), .ALUOPW(3), .CNTW(3), .TIMEOUT(TO)) dut (
    .CLK         (clk),
    .RST_n       (rst_n),
    .mem_if      (mif.master),
    .opcode_i    (op),
    .zero_i      (zero),
    .PCWre_o     (pcw),
    .IRWre_o     (irw),
    .RegWre_o    (regw),
    .DataMemRW_o (memrw),
    .ALUSrcB_o   (alusrcb),
    .ALUM2Reg_o  (alum2reg),
    .WrRegData_o (wrregdata),
    .ExtSel_o    (extsel),
    .RegOut_o    (regout),
    .PCSrc_o     (pcsrc),
    .ALUOp_o     (aluop),
    .state_o     (state),
    .retired_o   (retired),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nchk;
  int   nerr;
  int   mret;
  logic merr;
  logic mhalt;
  vec_t vq[$];
  vec_t tbl[13];

  function automatic exp_t mk(input logic [2:0] st, input logic [8:0] fl,
                              input logic [1:0] ext, input logic [1:0] ro,
                              input logic [1:0] ps, input logic [2:0] alu,
                              input logic [2:0] ret);
    return exp_t'({st, fl, ext, ro, ps, alu, ret, 1'b0});
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expected record with every control low, in state st
  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.ret = 3'(mret);
    e.err = merr;
    return e;
  endfunction

  task automatic check(input string name, input exp_t want);
    exp_t got;
    got = exp_t'({state, mif.ins_req, mif.data_req, pcw, irw, regw, memrw,
                  alusrcb, alum2reg, wrregdata, extsel, regout, pcsrc,
                  aluop, retired, err});
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s @%0t: got %h (st=%0d ret=%0d err=%b) want %h (st=%0d ret=%0d err=%b)",
               name, $time, got, got.st, got.ret, got.err,
               want, want.st, want.ret, want.err);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge and compare mid-cycle
  task automatic apply(input vec_t v, input string name);
    op           = v.op;
    zero         = v.z;
    mif.ins_ack  = v.ia;
    mif.data_ack = v.da;
    #1;
    check(name, v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string name);
    vec_t v;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      apply(v, name);
    end
  endtask

  task automatic push(input exp_t e, input logic [5:0] o, input logic z,
                      input logic ia, input logic da);
    vec_t v;
    v.op = o; v.z = z; v.ia = ia; v.da = da; v.e = e;
    vq.push_back(v);
  endtask

  // Reference model for one instruction. It emits the per-cycle control
  // picture for each phase, given the fetch and data-memory wait lengths.
  // A wait of TO or more ends in the error state.
  task automatic gen(input logic [5:0] o, input logic z, input int idly, input int ddly);
    exp_t e;
    logic ls;
    ls = (o == OP_LW) || (o == OP_SW);
    // fetch: request held until ack, ack with data_ack ignored
    e = blank(3'd0);
    e.ins_req = 1'b1;
    for (int k = 0; k < idly && k < TO; k++) push(e, 6'($urandom), rb(), 1'b0, rb());
    if (idly >= TO) begin
      merr = 1'b1;
      return;
    end
    e.irw = 1'b1;
    push(e, 6'($urandom), rb(), 1'b1, rb());
    // decode
    e = blank(3'd1);
    if (o == OP_J || o == OP_JAL || o == OP_JR) begin
      e.pcw   = 1'b1;
      e.pcsrc = (o == OP_JR) ? 2'b10 : 2'b11;
      e.regw  = (o == OP_JAL);
      push(e, o, rb(), rb(), rb());
      mret++;
      return;
    end
    push(e, o, rb(), rb(), rb());
    if (o == OP_HALT) begin
      mhalt = 1'b1;
      return;
    end
    if (o == OP_BEQ) begin
      e = blank(3'd3);
      e.pcw    = 1'b1;
      e.pcsrc  = z ? 2'b01 : 2'b00;
      e.aluop  = 3'd1;
      e.extsel = 2'b01;
      push(e, o, z, rb(), rb());
      mret++;
      return;
    end
    // execute
    e = blank(3'd2);
    e.alusrcb = (o != OP_R);
    e.aluop   = (o == OP_R) ? 3'd7 : (ls ? 3'd0 : o[2:0]);
    e.extsel  = (o == OP_ORI || o == OP_ANDI) ? 2'b00 : 2'b01;
    push(e, o, rb(), rb(), rb());
    if (ls) begin
      e = blank(3'd4);
      e.data_req = 1'b1;
      e.memrw    = (o == OP_SW);
      for (int k = 0; k < ddly && k < TO; k++) push(e, o, rb(), rb(), 1'b0);
      if (ddly >= TO) begin
        merr = 1'b1;
        return;
      end
      if (o == OP_SW) begin
        e.pcw = 1'b1;
        push(e, o, rb(), rb(), 1'b1);
        mret++;
        return;
      end
      push(e, o, rb(), rb(), 1'b1);
    end
    // write back
    e = blank(3'd5);
    e.regw      = 1'b1;
    e.pcw       = 1'b1;
    e.wrregdata = 1'b1;
    e.alum2reg  = (o == OP_LW);
    e.regout    = (o == OP_R) ? 2'b10 : 2'b01;
    push(e, o, rb(), rb(), rb());
    mret++;
  endtask

  // Absorbing HALT/ERR: nothing moves regardless of inputs
  task automatic push_dead(input int n);
    for (int k = 0; k < n; k++) push(blank(mhalt ? 3'd6 : 3'd7), 6'($urandom), rb(), rb(), rb());
  endtask

  task automatic do_reset();
    mret  = 0;
    merr  = 1'b0;
    mhalt = 1'b0;
    rst_n = 1'b0;
    mif.ins_ack  = 1'b1;
    mif.data_ack = 1'b1;
    #1;
    check("reset_outputs", mk(3'd0, 9'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] ops[10];
    nchk = 0; nerr = 0;
    rst_n = 1'b0; op = '0; zero = 1'b0;
    mif.ins_ack = 1'b0; mif.data_ack = 1'b0;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_JR, OP_ORI, OP_ANDI, OP_XI};

    // Directed table: add, one fetch wait with a stray data_ack, beq taken,
    // beq not taken with a stray ins_ack, then j
    tbl[0]  = '{OP_R,   1'b0, 1'b1, 1'b0, mk(3'd0, 9'b100100000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0)};
    tbl[1]  = '{OP_R,   1'b0, 1'b0, 1'b0, mk(3'd1, 9'b000000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0)};
    tbl[2]  = '{OP_R,   1'b0, 1'b0, 1'b0, mk(3'd2, 9'b000000000, 2'b01, 2'b00, 2'b00, 3'd7, 3'd0)};
    tbl[3]  = '{OP_R,   1'b0, 1'b0, 1'b0, mk(3'd5, 9'b001010001, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0)};
    tbl[4]  = '{OP_R,   1'b0, 1'b0, 1'b1, mk(3'd0, 9'b100000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1)};
    tbl[5]  = '{OP_R,   1'b0, 1'b1, 1'b0, mk(3'd0, 9'b100100000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1)};
    tbl[6]  = '{OP_BEQ, 1'b0, 1'b0, 1'b0, mk(3'd1, 9'b000000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1)};
    tbl[7]  = '{OP_BEQ, 1'b1, 1'b0, 1'b0, mk(3'd3, 9'b001000000, 2'b01, 2'b00, 2'b01, 3'd1, 3'd1)};
    tbl[8]  = '{OP_R,   1'b0, 1'b1, 1'b0, mk(3'd0, 9'b100100000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd2)};
    tbl[9]  = '{OP_BEQ, 1'b1, 1'b0, 1'b0, mk(3'd1, 9'b000000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd2)};
    tbl[10] = '{OP_BEQ, 1'b0, 1'b1, 1'b0, mk(3'd3, 9'b001000000, 2'b01, 2'b00, 2'b00, 3'd1, 3'd2)};
    tbl[11] = '{OP_R,   1'b0, 1'b1, 1'b0, mk(3'd0, 9'b100100000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd3)};
    tbl[12] = '{OP_J,   1'b0, 1'b0, 1'b0, mk(3'd1, 9'b001000000, 2'b00, 2'b00, 2'b11, 3'd0, 3'd3)};

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    // Randomised instruction stream against the model
    mret = 4;
    for (int i = 0; i < 80; i++) begin
      gen(ops[$urandom_range(9, 0)], rb(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end
    run_q("random");

    // lw with data_ack delayed three cycles, then sw with one wait
    gen(OP_LW, 1'b0, 0, 3);
    gen(OP_SW, 1'b0, 0, 1);
    run_q("lw_sw_delay");

    // Retired counter wrap after nine jumps, then HALT freezes everything
    do_reset();
    for (int i = 0; i < 9; i++) gen(OP_J, 1'b0, 0, 0);
    gen(OP_JAL, 1'b0, 1, 0);
    gen(OP_HALT, 1'b0, 0, 0);
    push_dead(8);
    run_q("wrap_halt");

    // Fetch timeout: four requesting cycles, then ERR held for 20 cycles
    do_reset();
    gen(OP_R, 1'b0, 9, 0);
    push_dead(20);
    run_q("fetch_timeout");

    // Data-memory timeout on a load
    do_reset();
    gen(OP_LW, 1'b0, 0, 9);
    push_dead(5);
    run_q("mem_timeout");

    // Reset asserted while a store is waiting in MEM
    do_reset();
    gen(OP_SW, 1'b0, 0, 9);
    // keep only IF, ID, EXE and one MEM cycle
    while (vq.size() > 4) void'(vq.pop_back());
    run_q("sw_to_mem");
    op = OP_SW; mif.data_ack = 1'b0; mif.ins_ack = 1'b0;
    #1;
    check("sw_mem_before_reset", mk(3'd4, 9'b010001000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0));
    rst_n = 1'b0;
    #1;
    check("sw_mem_reset_drop", mk(3'd0, 9'b000000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("after_reset_if", mk(3'd0, 9'b100000000, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0));
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
